clause_array: RTL

CLAUSE_ARRAY -- requirements
Module: clause_array

---
 rtl/sat_pkg.sv | 27 ++
 rtl/clause_eval.sv | 50 +++++
 rtl/clause_array.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/sat_pkg.sv
// Shared encodings for the clause array: literal and variable-value codes plus the FSM state type.
package sat_pkg;

  localparam logic [1:0] LIT_ABSENT = 2'b00;
  localparam logic [1:0] LIT_POS    = 2'b01;
  localparam logic [1:0] LIT_NEG    = 2'b10;

  localparam logic [1:0] VAL_FREE   = 2'b00;
  localparam logic [1:0] VAL_TRUE   = 2'b01;
  localparam logic [1:0] VAL_FALSE  = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  function automatic logic lit_present(input logic [1:0] lit);
    return (lit == LIT_POS) || (lit == LIT_NEG);
  endfunction

  // The value a free variable must take so that this literal becomes true.
  function automatic logic [1:0] lit_to_val(input logic [1:0] lit);
    return (lit == LIT_POS) ? VAL_TRUE : VAL_FALSE;
  endfunction

endpackage

// File: rtl/clause_eval.sv
// Combinational evaluation of one clause slot against the current variable values.
module clause_eval
  import sat_pkg::*;
#(
  parameter int NUM_VARS = 8,
  parameter int IDX_W    = (NUM_VARS > 1) ? $clog2(NUM_VARS) : 1
) (
  input  logic [2*NUM_VARS-1:0]         lits_i,
  input  logic [2*NUM_VARS-1:0]         vals_i,
  output logic                          sat_o,
  output logic [$clog2(NUM_VARS+1)-1:0] freecnt_o,
  output logic [IDX_W-1:0]              imp_idx_o,
  output logic [1:0]                    imp_val_o,
  output logic                          conflict_o
);

  localparam int CNT_W = $clog2(NUM_VARS + 1);

  logic any_lit;
  logic found;

  always_comb begin
    // NOTE: every output starts from a default so no path through the loop can infer a latch.
    sat_o     = 1'b0;
    freecnt_o = '0;
    imp_idx_o = '0;
    imp_val_o = VAL_FREE;
    any_lit   = 1'b0;
    found     = 1'b0;
    for (int i = 0; i < NUM_VARS; i++) begin
      if (lit_present(lits_i[2*i +: 2])) begin
        any_lit = 1'b1;
        if (vals_i[2*i +: 2] == lit_to_val(lits_i[2*i +: 2])) begin
          sat_o = 1'b1;
        end
        if (vals_i[2*i +: 2] == VAL_FREE) begin
          freecnt_o = freecnt_o + CNT_W'(1);
          // Lowest-index free literal is the implication candidate; only used when it is the sole one.
          if (!found) begin
            found     = 1'b1;
            imp_idx_o = IDX_W'(i);
            imp_val_o = lit_to_val(lits_i[2*i +: 2]);
          end
        end
      end
    end
    conflict_o = any_lit && !sat_o && (freecnt_o == '0);
  end

endmodule

// File: rtl/clause_array.sv
// Clause store with a unit-propagation engine: one slot evaluated per cycle, repeated passes until quiet.
module clause_array
  import sat_pkg::*;
#(
  parameter int NUM_VARS    = 8,
  parameter int NUM_CLAUSES = 8,
  parameter int MAX_PASSES  = 8
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             wr_i,
  input  logic [$clog2(NUM_CLAUSES)-1:0]   wr_addr_i,
  input  logic [NUM_VARS*2-1:0]            lits_i,
  input  logic                             clear_i,
  input  logic                             start_i,
  input  logic [NUM_VARS*3-1:0]            var_value_i,
  input  logic                             apply_backtrack_i,
  output logic                             busy_o,
  output logic                             done_o,
  output logic                             conflict_o,
  output logic [$clog2(NUM_CLAUSES)-1:0]   conflict_idx_o,
  output logic [NUM_VARS*3-1:0]            var_value_o,
  output logic [$clog2(NUM_VARS+1)-1:0]    imp_cnt_o
);

  localparam int AW = $clog2(NUM_CLAUSES);
  localparam int CW = $clog2(NUM_VARS + 1);
  localparam int IW = (NUM_VARS > 1) ? $clog2(NUM_VARS) : 1;
  localparam int PW = $clog2(MAX_PASSES + 1);

  state_e                 state_q, state_d;
  logic [AW-1:0]          slot_q, slot_d;
  logic [PW-1:0]          pass_cnt_q, pass_cnt_d;
  logic                   imp_pass_q, imp_pass_d;
  logic [NUM_VARS*3-1:0]  var_q, var_d;
  logic [CW-1:0]          imp_cnt_q, imp_cnt_d;
  logic                   conflict_q, conflict_d;
  logic [AW-1:0]          conflict_idx_q, conflict_idx_d;
  logic [NUM_CLAUSES-1:0] valid_q, valid_d;
  logic [2*NUM_VARS-1:0]  mem_q [NUM_CLAUSES];
  logic                   mem_we;
  logic                   imp_now;

  logic [2*NUM_VARS-1:0]  slot_lits;
  logic [2*NUM_VARS-1:0]  cur_vals;
  logic                   ev_sat;
  logic [CW-1:0]          ev_freecnt;
  logic [IW-1:0]          ev_imp_idx;
  logic [1:0]             ev_imp_val;
  logic                   ev_conflict;

  // An invalid slot presents no literals, which the evaluator treats as a no-op.
  always_comb begin
    slot_lits = valid_q[slot_q] ? mem_q[slot_q] : '0;
    cur_vals  = '0;
    for (int i = 0; i < NUM_VARS; i++) begin
      cur_vals[2*i +: 2] = var_q[3*i +: 2];
    end
  end

  clause_eval #(
    .NUM_VARS (NUM_VARS),
    .IDX_W    (IW)
  ) u_eval (
    .lits_i     (slot_lits),
    .vals_i     (cur_vals),
    .sat_o      (ev_sat),
    .freecnt_o  (ev_freecnt),
    .imp_idx_o  (ev_imp_idx),
    .imp_val_o  (ev_imp_val),
    .conflict_o (ev_conflict)
  );

  always_comb begin
    state_d        = state_q;
    slot_d         = slot_q;
    pass_cnt_d     = pass_cnt_q;
    imp_pass_d     = imp_pass_q;
    var_d          = var_q;
    imp_cnt_d      = imp_cnt_q;
    conflict_d     = conflict_q;
    conflict_idx_d = conflict_idx_q;
    valid_d        = valid_q;
    mem_we         = 1'b0;
    imp_now        = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          var_d          = var_value_i;
          imp_cnt_d      = '0;
          pass_cnt_d     = '0;
          imp_pass_d     = 1'b0;
          slot_d         = '0;
          conflict_d     = 1'b0;
          conflict_idx_d = '0;
          state_d        = ST_SCAN;
        end else begin
          if (clear_i) begin
            valid_d = '0;
          end else if (wr_i) begin
            valid_d[wr_addr_i] = 1'b1;
            mem_we             = 1'b1;
          end
          if (apply_backtrack_i) begin
            for (int i = 0; i < NUM_VARS; i++) begin
              if (var_q[3*i+2]) var_d[3*i +: 3] = 3'b000;
            end
          end
        end
      end

      ST_SCAN: begin
        if (ev_conflict) begin
          conflict_d     = 1'b1;
          conflict_idx_d = slot_q;
          state_d        = ST_DONE;
        end else begin
          if (!ev_sat && (ev_freecnt == CW'(1))) begin
            var_d[3*ev_imp_idx +: 3] = {1'b1, ev_imp_val};
            imp_cnt_d                = imp_cnt_q + CW'(1);
            imp_pass_d               = 1'b1;
            imp_now                  = 1'b1;
          end
          if (slot_q == AW'(NUM_CLAUSES - 1)) begin
            pass_cnt_d = pass_cnt_q + PW'(1);
            if ((imp_pass_q || imp_now) && (int'(pass_cnt_q) + 1 < MAX_PASSES)) begin
              slot_d     = '0;
              imp_pass_d = 1'b0;
            end else begin
              state_d = ST_DONE;
            end
          end else begin
            slot_d = slot_q + AW'(1);
          end
        end
      end

      ST_DONE: state_d = ST_IDLE;

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      state_q        <= ST_IDLE;
      slot_q         <= '0;
      pass_cnt_q     <= '0;
      imp_pass_q     <= 1'b0;
      var_q          <= '0;
      imp_cnt_q      <= '0;
      conflict_q     <= 1'b0;
      conflict_idx_q <= '0;
      valid_q        <= '0;
    end else begin
      state_q        <= state_d;
      slot_q         <= slot_d;
      pass_cnt_q     <= pass_cnt_d;
      imp_pass_q     <= imp_pass_d;
      var_q          <= var_d;
      imp_cnt_q      <= imp_cnt_d;
      conflict_q     <= conflict_d;
      conflict_idx_q <= conflict_idx_d;
      valid_q        <= valid_d;
    end
  end

  // NOTE: clause storage is not reset; the valid bits alone decide whether a slot's contents matter.
  always_ff @(posedge clk) begin
    if (mem_we) mem_q[wr_addr_i] <= lits_i;
  end

  assign busy_o         = (state_q != ST_IDLE);
  assign done_o         = (state_q == ST_DONE);
  assign conflict_o     = conflict_q;
  assign conflict_idx_o = conflict_idx_q;
  assign var_value_o    = var_q;
  assign imp_cnt_o      = imp_cnt_q;

endmodule
